restoring_multiplier: RTL and testbench

Sequential shift-add multiplier/reconstructor: the inverse of the restoring divider. It takes a quotient, a divisor and a remainder and rebuilds the dividend as quotient*divisor + remainder over multiple cycles. It sits beside the divider as a check path: a divider result fed back in must reproduce the original 13-bit dividend. It uses a start/busy/done handshake with one iteration per clock.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_controller.sv | 81 ++++++++
 rtl/restoring_multiplier.sv | 67 ++++++
 tb/tb_restoring_multiplier.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared state encoding and default widths for the restoring multiplier.
package mult_pkg;
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int QW_D = 6;
  localparam int DW_D = 6;
  localparam int RW_D = 7;
  localparam int PW_D = 13;
endpackage

// File: rtl/mult_controller.sv
// Sequencer for the shift-add multiplier: FSM, iteration counter, busy/done.
// Optional EARLY_TERM_EN ends iteration once the remaining multiplier bits are zero.
//
// state  | meaning
// S_IDLE | waiting for start; operands load on the launching edge
// S_CALC | one shift-add iteration per clock
// S_DONE | single-cycle done pulse, product registered
module mult_controller
  import mult_pkg::*;
#(
  parameter int QW = QW_D,
  parameter int CW = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mplier_lsb,
`ifdef EARLY_TERM_EN
  input  logic mplier_last,
`endif
  output logic ld,
  output logic sh,
  output logic add_en,
  output logic fin,
  output logic busy,
  output logic done
);

  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic last_iter;

`ifdef EARLY_TERM_EN
  assign last_iter = (cnt == CW'(QW - 1)) || mplier_last;
`else
  assign last_iter = (cnt == CW'(QW - 1));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (ld)
        cnt <= '0;
      else if (sh)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    sh        = 1'b0;
    add_en    = 1'b0;
    fin       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          ld        = 1'b1;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        sh     = 1'b1;
        add_en = mplier_lsb;
        if (last_iter) begin
          fin       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

endmodule

// File: rtl/restoring_multiplier.sv
// Rebuilds a dividend as quotient*divisor + rem with one shift-add per clock.
// Optional EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module restoring_multiplier
  import mult_pkg::*;
#(
  parameter int QW = QW_D,
  parameter int DW = DW_D,
  parameter int RW = RW_D,
  parameter int PW = PW_D,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [QW-1:0] quotient,
  input  logic [DW-1:0] divisor,
  input  logic [RW-1:0] rem,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] dividend
);

  logic [PW-1:0] acc, acc_nxt, mcand;
  logic [QW-1:0] mplier;
  logic ld, sh, add_en, fin;

  mult_controller #(.QW(QW), .CW(CW)) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .mplier_lsb  (mplier[0]),
`ifdef EARLY_TERM_EN
    .mplier_last (~|mplier[QW-1:1]),
`endif
    .ld          (ld),
    .sh          (sh),
    .add_en      (add_en),
    .fin         (fin),
    .busy        (busy),
    .done        (done)
  );

  // PW is sized so this sum never wraps.
  assign acc_nxt = add_en ? acc + mcand : acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      dividend <= '0;
    end else begin
      if (ld) begin
        acc    <= PW'(rem);
        mcand  <= PW'(divisor);
        mplier <= quotient;
      end else if (sh) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (fin)
        dividend <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_restoring_multiplier.sv
// Self-checking bench for restoring_multiplier: directed cases plus random jobs
// against an arithmetic reference (q*d + r) and a latency model.
module tb_restoring_multiplier;
  localparam int QW = 6;
  localparam int DW = 6;
  localparam int RW = 7;
  localparam int PW = 13;

  logic          clk;
  logic          rst;
  logic          start;
  logic [QW-1:0] quotient;
  logic [DW-1:0] divisor;
  logic [RW-1:0] rem;
  logic          busy;
  logic          done;
  logic [PW-1:0] dividend;

  int checks = 0;
  int failures = 0;

  restoring_multiplier dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .quotient (quotient),
    .divisor  (divisor),
    .rem      (rem),
    .busy     (busy),
    .done     (done),
    .dividend (dividend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Number of CALC cycles a job takes.
  function automatic int iters(input int q);
`ifdef EARLY_TERM_EN
    int n;
    n = 0;
    while ((q >> n) != 0) n++;
    return (n == 0) ? 1 : n;
`else
    return QW;
`endif
  endfunction

  // Called just after a negedge; returns just after the negedge following done.
  task automatic run_job(input int q, input int d, input int r, input string tag);
    int lat;
    int bcnt;
    bit seen;
    quotient = QW'(q);
    divisor  = DW'(d);
    rem      = RW'(r);
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 1;
    bcnt = 0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bcnt++;
      @(posedge clk);
      lat++;
    end
    chk({tag, "_timeout"}, int'(seen), 1);
    chk({tag, "_dividend"}, int'(dividend), q * d + r);
    chk({tag, "_latency"}, lat, iters(q) + 1);
    chk({tag, "_busy_cycles"}, bcnt, iters(q));
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int dcnt;
    int cyc;
    int dcyc[$];
    int q, d, r;

    rst      = 1'b0;
    start    = 1'b0;
    quotient = '0;
    divisor  = '0;
    rem      = '0;
    #3;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_dividend", int'(dividend), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    run_job(25, 5, 3, "t25x5");
    run_job(63, 63, 127, "tmax");
    run_job(0, 41, 17, "tzero");

    // start pulse during CALC with new operands must be ignored
    quotient = 6'd12; divisor = 6'd11; rem = 7'd9;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    quotient = 6'd50; divisor = 6'd50; rem = 7'd50;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) begin
        dcnt++;
        if (dcnt == 1) chk("ign_dividend", int'(dividend), 12 * 11 + 9);
      end
    end
    chk("ign_done_count", dcnt, 1);

    // async reset in the middle of a job
    quotient = 6'd10; divisor = 6'd10; rem = 7'd0;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_pre_busy", int'(busy), (iters(10) >= 4) ? 1 : 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_done", int'(done), 0);
    chk("rst_mid_dividend", int'(dividend), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("rst_no_stale_done", int'(done), 0);
    run_job(10, 10, 0, "post_rst");

    // start held high: back-to-back jobs
    quotient = 6'd7; divisor = 6'd9; rem = 7'd5;
    start = 1'b1;
    cyc = 0;
    for (int i = 0; i < 4 * (QW + 2) + 4; i++) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        dcyc.push_back(cyc);
        chk("hold_dividend", int'(dividend), 68);
      end
    end
    start = 1'b0;
    chk("hold_done_count_ok", int'(dcyc.size() >= 3), 1);
    if (dcyc.size() >= 3) begin
      chk("hold_spacing1", dcyc[1] - dcyc[0], iters(7) + 2);
      chk("hold_spacing2", dcyc[2] - dcyc[1], iters(7) + 2);
    end
    repeat (QW + 4) @(negedge clk);

    // random jobs
    for (int k = 0; k < 16; k++) begin
      q = int'($urandom_range(0, 63));
      d = int'($urandom_range(0, 63));
      r = int'($urandom_range(0, 127));
      run_job(q, d, r, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
